// File: rtl/gcd_lcm_coprocessor.sv
// GCD/LCM coprocessor answering the core's start/done handshake.
// GCD by repeated subtraction; LCM = (A / gcd) * B via restoring division then shift-add.
module gcd_lcm_coprocessor #(
   parameter int W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] cmd,
   output logic [31:0] ans
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_GCD  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_MUL  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam int         CW     = $clog2(W);

   logic [2:0]     state_q, state_d;
   logic [W-1:0]   x_q, x_d, y_q, y_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, g_q, g_d;
   logic           op_q, op_d;
   logic [W-1:0]   rem_q, rem_d, quot_q, quot_d;
   logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   res_q, res_d;
   logic           ovf_q, ovf_d, done_q, done_d;

   logic [W-1:0]   g_now;
   logic [W:0]     trial, diff;
   logic           trial_ge, last;
   logic [2*W-1:0] p_now;
   logic           unused_cmd_bits;

   assign g_now           = x_q | y_q;
   assign trial           = {rem_q, quot_q[W-1]};
   assign diff            = trial - {1'b0, g_q};
   assign trial_ge        = (trial >= {1'b0, g_q});
   assign p_now           = acc_q + (quot_q[0] ? mcand_q : '0);
   assign last            = (cnt_q == CW'(W - 1));
   assign unused_cmd_bits = ^cmd[31:2*W+1];
   assign ans             = {{(32 - W - 2){1'b0}}, ovf_q, done_q, res_q};

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      a_d     = a_q;
      b_d     = b_q;
      g_d     = g_q;
      op_d    = op_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE: begin
            done_d = 1'b0;
            if (start) begin
               x_d     = cmd[W-1:0];
               y_d     = cmd[2*W-1:W];
               a_d     = cmd[W-1:0];
               b_d     = cmd[2*W-1:W];
               op_d    = cmd[2*W];
               ovf_d   = 1'b0;
               state_d = S_GCD;
            end
         end
         S_GCD: begin
            if (x_q == y_q || x_q == '0 || y_q == '0) begin
               if (!op_q) begin
                  res_d   = g_now;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else if (x_q == '0 || y_q == '0) begin
                  res_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  // quot_q starts as the dividend and is shifted out MSB first
                  g_d     = g_now;
                  rem_d   = '0;
                  quot_d  = a_q;
                  cnt_d   = '0;
                  state_d = S_DIV;
               end
            end else if (x_q > y_q) begin
               x_d = x_q - y_q;
            end else begin
               y_d = y_q - x_q;
            end
         end
         S_DIV: begin
            rem_d  = trial_ge ? diff[W-1:0] : trial[W-1:0];
            quot_d = {quot_q[W-2:0], trial_ge};
            cnt_d  = cnt_q + CW'(1);
            if (last) begin
               cnt_d   = '0;
               acc_d   = '0;
               mcand_d = {{W{1'b0}}, b_q};
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            acc_d   = p_now;
            mcand_d = mcand_q << 1;
            quot_d  = quot_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               cnt_d   = '0;
               res_d   = p_now[W-1:0];
               ovf_d   = |p_now[2*W-1:W];
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         g_q     <= '0;
         op_q    <= 1'b0;
         rem_q   <= '0;
         quot_q  <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         a_q     <= a_d;
         b_q     <= b_d;
         g_q     <= g_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_gcd_lcm_coprocessor.sv
// Directed bench for gcd_lcm_coprocessor: vector table plus reset, back-to-back and mid-op reset sequences.
module tb_gcd_lcm_coprocessor;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] cmd   = '0;
   logic [31:0] ans;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   gcd_lcm_coprocessor #(.W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .cmd   (cmd),
      .ans   (ans)
   );

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      logic       op;
      logic [31:0] exp;
      int         lat;
   } vec_t;

   vec_t vecs[13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // start is asserted before edge E0; done must appear only after edge E(lat)
   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic op, input logic [31:0] exp, input int lat, input bit keep);
      int early;
      int spurious;
      early    = 0;
      spurious = 0;
      cmd      = {15'h5A5A, op, b, a};
      start    = 1'b1;
      step();
      for (int i = 1; i <= lat; i++) begin
         step();
         if (i < lat && ans[8]) early++;
      end
      check({name, " early_done"}, 32'(early), 32'd0);
      check({name, " ans"}, ans, exp);
      $display("[TB] op %s a=%0d b=%0d lcm=%0d ans=0x%0h", name, a, b, op, ans);
      step();
      check({name, " done_pulse"}, {23'd0, ans[8:0]}, {24'd0, exp[7:0]});
      if (!keep) begin
         start = 1'b0;
         for (int i = 0; i < lat + 2; i++) begin
            step();
            if (ans[8]) spurious++;
         end
         check({name, " no_retrigger"}, 32'(spurious), 32'd0);
      end
   endtask

   initial begin
      vecs[0]  = '{"gcd_12_18",   8'd12,  8'd18,  1'b0, 32'h106, 3};
      vecs[1]  = '{"lcm_4_6",     8'd4,   8'd6,   1'b1, 32'h10C, 19};
      vecs[2]  = '{"lcm_200_150", 8'd200, 8'd150, 1'b1, 32'h358, 20};
      vecs[3]  = '{"gcd_0_9",     8'd0,   8'd9,   1'b0, 32'h109, 1};
      vecs[4]  = '{"gcd_0_0",     8'd0,   8'd0,   1'b0, 32'h100, 1};
      vecs[5]  = '{"lcm_0_7",     8'd0,   8'd7,   1'b1, 32'h100, 1};
      vecs[6]  = '{"lcm_5_0",     8'd5,   8'd0,   1'b1, 32'h100, 1};
      vecs[7]  = '{"gcd_7_7",     8'd7,   8'd7,   1'b0, 32'h107, 1};
      vecs[8]  = '{"lcm_16_16",   8'd16,  8'd16,  1'b1, 32'h110, 17};
      vecs[9]  = '{"gcd_48_36",   8'd48,  8'd36,  1'b0, 32'h10C, 4};
      vecs[10] = '{"lcm_15_17",   8'd15,  8'd17,  1'b1, 32'h1FF, 26};
      vecs[11] = '{"lcm_16_17",   8'd16,  8'd17,  1'b1, 32'h310, 33};
      vecs[12] = '{"lcm_255_254", 8'd255, 8'd254, 1'b1, 32'h302, 271};

      // T1: reset held with a pending request, then released
      reset = 1'b0;
      start = 1'b1;
      cmd   = {15'h0, 1'b0, 8'd18, 8'd12};
      step();
      check("reset_edge1", ans, 32'h0);
      step();
      check("reset_edge2", ans, 32'h0);
      reset = 1'b1;
      run_op("T1_gcd_12_18", 8'd12, 8'd18, 1'b0, 32'h106, 3, 1'b0);

      for (int i = 0; i < 13; i++)
         run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].lat, 1'b0);

      // T5: start stays high across DONE; cmd swapped in the IDLE cycle
      run_op("T5_gcd_12_18", 8'd12, 8'd18, 1'b0, 32'h106, 3, 1'b1);
      run_op("T5_lcm_3_5", 8'd3, 8'd5, 1'b1, 32'h10F, 20, 1'b0);

      // T6: reset in the middle of the division phase, then reissue
      cmd   = {15'h0, 1'b1, 8'd6, 8'd4};
      start = 1'b1;
      step();
      for (int i = 0; i < 6; i++) step();
      check("T6_no_done_before_reset", {31'd0, ans[8]}, 32'd0);
      reset = 1'b0;
      step();
      check("T6_reset_ans", ans, 32'h0);
      step();
      check("T6_reset_hold", ans, 32'h0);
      reset = 1'b1;
      run_op("T6_lcm_4_6_reissue", 8'd4, 8'd6, 1'b1, 32'h10C, 19, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
